// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: FIFO-queued command sequencer driving a universal shift register's ctrl/data for a commanded number of clocks
module shift_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_mode,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic [1:0]       o_ctrl,
    output logic [WIDTH-1:0] o_d,
    output logic             o_done,
    output logic             o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + LEN_W + WIDTH;
    typedef enum logic {IDLE, EXEC} state_t;
    state_t           state;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       h_mode;
    logic [LEN_W-1:0] h_len;
    logic [WIDTH-1:0] h_data;
    logic             full, empty, push, pop;
    always_comb begin
        {h_mode, h_len, h_data} = mem[rd_ptr];
        full        = count == (AW+1)'(DEPTH);
        empty       = count == '0;
        o_cmd_ready = !i_rst && !full;
        push        = i_cmd_valid && o_cmd_ready;
        pop         = !empty && (state == IDLE || remaining == '0);
        o_busy      = state == EXEC || !empty;
    end
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_cmd_mode, i_cmd_len, i_cmd_data};
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            remaining <= '0;
            o_ctrl    <= 2'b00;
            o_d       <= '0;
            o_done    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                state     <= EXEC;
                o_ctrl    <= h_len == '0 ? 2'b00 : h_mode;
                o_d       <= h_data;
                remaining <= h_len == '0 ? '0 : h_len - 1'b1;
                o_done    <= h_len <= LEN_W'(1);
            end else if (state == EXEC && remaining != '0) begin
                remaining <= remaining - 1'b1;
                o_done    <= remaining == LEN_W'(1);
            end else begin
                state  <= IDLE;
                o_ctrl <= 2'b00;
                o_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb_shift_cmd_sequencer: table-driven, cycle-model scoreboard bench for shift_cmd_sequencer
module tb_shift_cmd_sequencer;
    localparam int DEPTH = 4;
    typedef struct {
        logic [1:0] mode;
        logic [3:0] len;
        logic [7:0] data;
        logic [1:0] ec;
        int         n;
    } vec_t;
    typedef struct {
        logic [1:0] c;
        logic [7:0] d;
        logic       dn;
        logic       first;
    } cyc_t;
    logic       i_clk = 0, i_rst = 1, i_cmd_valid = 0;
    logic [1:0] i_cmd_mode = 0;
    logic [3:0] i_cmd_len = 0;
    logic [7:0] i_cmd_data = 0;
    logic       o_cmd_ready, o_done, o_busy;
    logic [1:0] o_ctrl;
    logic [7:0] o_d;
    shift_cmd_sequencer #(.WIDTH(8), .DEPTH(DEPTH), .LEN_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_mode(i_cmd_mode), .i_cmd_len(i_cmd_len), .i_cmd_data(i_cmd_data),
        .o_ctrl(o_ctrl), .o_d(o_d), .o_done(o_done), .o_busy(o_busy)
    );
    always #5 i_clk = ~i_clk;
    int   compared = 0, mismatched = 0;
    vec_t tv [14];
    vec_t cv;
    cyc_t q[$];
    int   nq = 0;
    logic cur_v = 0, e_done = 0, saw_low = 0;
    logic [1:0] e_ctrl = 0;
    logic [7:0] e_d = 0;
    logic [1:0] obs_ctrl[$];
    logic       obs_done[$];
    bit   p;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic check_outs();
        chk("ctrl", 32'(o_ctrl), 32'(e_ctrl));
        chk("d", 32'(o_d), 32'(e_d));
        chk("done", 32'(o_done), 32'(e_done));
        chk("busy", 32'(o_busy), 32'(cur_v || nq > 0));
        chk("ready", 32'(o_cmd_ready), 32'(!i_rst && nq < DEPTH));
    endtask
    task automatic clear_model();
        q.delete();
        nq = 0;
        cur_v = 0;
        e_ctrl = 0;
        e_d = 0;
        e_done = 0;
    endtask
    task automatic tick(output bit pushed);
        cyc_t r;
        pushed = i_cmd_valid && !i_rst && nq < DEPTH;
        @(posedge i_clk);
        if (!i_rst) begin
            if (q.size() != 0) begin
                r = q.pop_front();
                if (r.first) nq--;
                e_ctrl = r.c;
                e_d = r.d;
                e_done = r.dn;
                cur_v = 1;
            end else begin
                e_ctrl = 0;
                e_done = 0;
                cur_v = 0;
            end
            if (pushed) begin
                for (int k = 0; k < cv.n; k++) q.push_back('{cv.ec, cv.data, k == cv.n - 1, k == 0});
                nq++;
            end
        end
        @(negedge i_clk);
        obs_ctrl.push_back(o_ctrl);
        obs_done.push_back(o_done);
        if (!i_rst && o_cmd_ready === 1'b0) saw_low = 1;
        check_outs();
    endtask
    task automatic send(input int i);
        bit pushed;
        cv = tv[i];
        i_cmd_mode = cv.mode;
        i_cmd_len = cv.len;
        i_cmd_data = cv.data;
        i_cmd_valid = 1;
        pushed = 0;
        for (int t = 0; t < 200 && !pushed; t++) tick(pushed);
        chk("send_accept", 32'(pushed), 32'd1);
    endtask
    task automatic drain();
        bit pp;
        for (int t = 0; t < 400 && (q.size() != 0 || cur_v); t++) tick(pp);
        chk("drain_idle", 32'(q.size() != 0 || cur_v), 32'd0);
        tick(pp);
        tick(pp);
    endtask
    task automatic async_reset(input int cycles);
        bit pp;
        i_rst = 1;
        clear_model();
        #1;
        chk("rst_ctrl", 32'(o_ctrl), 32'd0);
        chk("rst_d", 32'(o_d), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(o_cmd_ready), 32'd0);
        repeat (cycles) tick(pp);
        i_rst = 0;
        #1;
        chk("rel_ready", 32'(o_cmd_ready), 32'd1);
        chk("rel_busy", 32'(o_busy), 32'd0);
        chk("rel_ctrl", 32'(o_ctrl), 32'd0);
    endtask
    initial begin
        logic [1:0] seq_c [7];
        logic       seq_d [7];
        tv[0]  = '{2'd3, 4'd1,  8'hF1, 2'd3, 1};
        tv[1]  = '{2'd3, 4'd1,  8'hF1, 2'd3, 1};
        tv[2]  = '{2'd1, 4'd3,  8'h3C, 2'd1, 3};
        tv[3]  = '{2'd2, 4'd2,  8'h5A, 2'd2, 2};
        tv[4]  = '{2'd1, 4'd15, 8'h01, 2'd1, 15};
        tv[5]  = '{2'd2, 4'd15, 8'h02, 2'd2, 15};
        tv[6]  = '{2'd3, 4'd15, 8'h03, 2'd3, 15};
        tv[7]  = '{2'd0, 4'd15, 8'h04, 2'd0, 15};
        tv[8]  = '{2'd1, 4'd15, 8'h05, 2'd1, 15};
        tv[9]  = '{2'd2, 4'd15, 8'h06, 2'd2, 15};
        tv[10] = '{2'd1, 4'd0,  8'hAA, 2'd0, 1};
        tv[11] = '{2'd2, 4'd15, 8'h77, 2'd2, 15};
        tv[12] = '{2'd1, 4'd4,  8'h11, 2'd1, 4};
        tv[13] = '{2'd3, 4'd2,  8'h22, 2'd3, 2};
        seq_c = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        seq_d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge i_clk);
        async_reset(10);
        tick(p);
        send(0);
        i_cmd_valid = 0;
        drain();
        obs_ctrl.delete();
        obs_done.delete();
        for (int i = 1; i <= 3; i++) send(i);
        i_cmd_valid = 0;
        repeat (5) tick(p);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("seq_ctrl%0d", i), 32'(obs_ctrl[i+1]), 32'(seq_c[i]));
            chk($sformatf("seq_done%0d", i), 32'(obs_done[i+1]), 32'(seq_d[i]));
        end
        drain();
        saw_low = 0;
        for (int i = 4; i <= 9; i++) send(i);
        i_cmd_valid = 0;
        chk("ready_dropped", 32'(saw_low), 32'd1);
        drain();
        send(10);
        i_cmd_valid = 0;
        drain();
        for (int i = 11; i <= 13; i++) send(i);
        i_cmd_valid = 0;
        repeat (4) tick(p);
        async_reset(2);
        repeat (20) tick(p);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
